cpu_control_unit: RTL and testbench

Multi-cycle control unit that sits directly upstream of cpuDatapath. It owns the PC and instruction register, fetches 16-bit instructions, decodes them into the datapath control word (DA, AA, BA, FS, MB, resultSource, RW) and sequences fetch/decode/execute/memory. It consumes the datapath zero and negative flags for conditional branches.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/cpu_decoder.sv | 117 +++++++++++
 rtl/cpu_control_unit.sv | 144 ++++++++++++++
 tb/tb_cpu_control_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the multi-cycle CPU control unit:
//               opcode map, FSM state encoding, write-back source codes and
//               ALU function-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Opcodes, IR[15:12]
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BN   = 4'hD;
  localparam logic [3:0] OP_JAL  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Sequencer states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Write-back source select
  localparam logic [1:0] RS_ALU = 2'd0;
  localparam logic [1:0] RS_MEM = 2'd1;
  localparam logic [1:0] RS_PC  = 2'd2;
  localparam logic [1:0] RS_IMM = 2'd3;

  // ALU function select (ALU opcodes map directly onto op[2:0])
  localparam logic [2:0] FS_ADD = 3'd0;
  localparam logic [2:0] FS_SUB = 3'd1;
  localparam logic [2:0] FS_AND = 3'd2;
  localparam logic [2:0] FS_OR  = 3'd3;
  localparam logic [2:0] FS_XOR = 3'd4;
  localparam logic [2:0] FS_NOT = 3'd5;
  localparam logic [2:0] FS_SHL = 3'd6;
  localparam logic [2:0] FS_SHR = 3'd7;

endpackage
`default_nettype wire

// File: rtl/cpu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_decoder
// Description : Purely combinational instruction decoder. Turns the
//               instruction register into the datapath control fields and
//               a set of instruction-class flags used by the sequencer.
// Revision    : 1.0 - initial release
// Ports       : ir            - instruction register
//               da/aa/ba      - destination / A / B register addresses
//               fs            - ALU function select
//               mb            - B operand select (1 = imm)
//               imm           - extended constant
//               result_source - write-back source
//               is_alu        - writes a result in EXEC (ALU ops, ADDI, LDI)
//               is_ld/is_st/is_br/is_jal/is_halt - class flags
// ============================================================================
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir,
  output logic [3:0]        da,
  output logic [3:0]        aa,
  output logic [3:0]        ba,
  output logic [2:0]        fs,
  output logic              mb,
  output logic [DATA_W-1:0] imm,
  output logic [1:0]        result_source,
  output logic              is_alu,
  output logic              is_ld,
  output logic              is_st,
  output logic              is_br,
  output logic              is_jal,
  output logic              is_halt
);

  logic [3:0] op;
  logic [3:0] fd;
  logic [3:0] fa;
  logic [3:0] fb;
  logic [7:0] off8;

  assign op   = ir[15:12];
  assign fd   = ir[11:8];
  assign fa   = ir[7:4];
  assign fb   = ir[3:0];
  assign off8 = ir[7:0];

  always_comb begin
    da            = 4'd0;
    aa            = 4'd0;
    ba            = 4'd0;
    fs            = FS_ADD;
    mb            = 1'b0;
    imm           = '0;
    result_source = RS_ALU;
    is_alu        = 1'b0;
    is_ld         = 1'b0;
    is_st         = 1'b0;
    is_br         = 1'b0;
    is_jal        = 1'b0;
    is_halt       = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
        da     = fd;
        aa     = fa;
        ba     = fb;
        fs     = op[2:0];
        is_alu = 1'b1;
      end
      OP_ADDI: begin
        da     = fd;
        aa     = fa;
        mb     = 1'b1;
        imm    = {{(DATA_W-4){1'b0}}, fb};
        is_alu = 1'b1;
      end
      OP_LDI: begin
        da            = fd;
        imm           = {{(DATA_W-8){off8[7]}}, off8};
        result_source = RS_IMM;
        is_alu        = 1'b1;
      end
      OP_LD: begin
        // The ALU computes R[a] + 0, which the datapath uses as MemAddr.
        da            = fd;
        aa            = fa;
        mb            = 1'b1;
        result_source = RS_MEM;
        is_ld         = 1'b1;
      end
      OP_ST: begin
        aa    = fa;
        ba    = fb;
        mb    = 1'b1;
        is_st = 1'b1;
      end
      OP_BZ, OP_BN: begin
        // R[d] + 0 through the ALU produces the flags being tested.
        aa    = fd;
        mb    = 1'b1;
        is_br = 1'b1;
      end
      OP_JAL: begin
        da            = fd;
        result_source = RS_PC;
        is_jal        = 1'b1;
      end
      default: begin
        is_halt = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_unit
// Description : Multi-cycle control unit in front of cpuDatapath. Holds PC
//               and IR, fetches 16-bit instructions and sequences
//               FETCH -> DECODE -> EXEC -> (MEM) -> FETCH, plus HALT.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (sync, active high)
//               MemIn        - memory read data (instruction during FETCH)
//               zero/negative- datapath flags, valid in EXEC
//               PC, addrSel  - program counter and memory address select
//               DA/AA/BA/FS/MB/imm/resultSource - datapath control word
//               RW, memWrite - register / memory write enables
//               instrDone    - pulse in the last cycle of an instruction
//               halted       - high in HALT
// ============================================================================
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] MemIn,
  input  logic              zero,
  input  logic              negative,
  output logic [DATA_W-1:0] PC,
  output logic              addrSel,
  output logic [3:0]        DA,
  output logic [3:0]        AA,
  output logic [3:0]        BA,
  output logic [2:0]        FS,
  output logic              MB,
  output logic [DATA_W-1:0] imm,
  output logic [1:0]        resultSource,
  output logic              RW,
  output logic              memWrite,
  output logic              instrDone,
  output logic              halted
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] br_target;
  logic              br_taken;
  logic              is_alu;
  logic              is_ld;
  logic              is_st;
  logic              is_br;
  logic              is_jal;
  logic              is_halt;

  cpu_decoder #(
    .DATA_W(DATA_W)
  ) u_decoder (
    .ir           (ir),
    .da           (DA),
    .aa           (AA),
    .ba           (BA),
    .fs           (FS),
    .mb           (MB),
    .imm          (imm),
    .result_source(resultSource),
    .is_alu       (is_alu),
    .is_ld        (is_ld),
    .is_st        (is_st),
    .is_br        (is_br),
    .is_jal       (is_jal),
    .is_halt      (is_halt)
  );

  assign PC = pc;

  // pc already points past the branch/JAL here, so offset -1 loops to itself.
  assign br_target = pc + {{(DATA_W-8){ir[7]}}, ir[7:0]};
  // BZ (C) and BN (D) differ only in IR[12].
  assign br_taken  = ir[12] ? negative : zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == S_FETCH) begin
        ir <= MemIn;
      end
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    addrSel    = 1'b0;
    RW         = 1'b0;
    memWrite   = 1'b0;
    instrDone  = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        pc_next    = pc + DATA_W'(1);
        state_next = S_DECODE;
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (is_ld || is_st) begin
          state_next = S_MEM;
        end else if (is_halt) begin
          state_next = S_HALT;
        end else begin
          state_next = S_FETCH;
          instrDone  = 1'b1;
          RW         = is_alu | is_jal;
          if (is_jal || (is_br && br_taken)) begin
            pc_next = br_target;
          end
        end
      end
      S_MEM: begin
        addrSel    = 1'b1;
        RW         = is_ld;
        memWrite   = is_st;
        instrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_unit
// Description : Scoreboard bench for cpu_control_unit. The driver pushes the
//               expected control word of each instruction; a monitor pops
//               and compares it whenever instrDone is seen.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] MemIn = 16'h0000;
  logic        zero = 1'b0;
  logic        negative = 1'b0;
  logic [15:0] PC;
  logic        addrSel;
  logic [3:0]  DA;
  logic [3:0]  AA;
  logic [3:0]  BA;
  logic [2:0]  FS;
  logic        MB;
  logic [15:0] imm;
  logic [1:0]  resultSource;
  logic        RW;
  logic        memWrite;
  logic        instrDone;
  logic        halted;

  cpu_control_unit #(
    .DATA_W  (16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemIn       (MemIn),
    .zero        (zero),
    .negative    (negative),
    .PC          (PC),
    .addrSel     (addrSel),
    .DA          (DA),
    .AA          (AA),
    .BA          (BA),
    .FS          (FS),
    .MB          (MB),
    .imm         (imm),
    .resultSource(resultSource),
    .RW          (RW),
    .memWrite    (memWrite),
    .instrDone   (instrDone),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Field value -1 means "not constrained for this instruction".
  typedef struct {
    logic [15:0] instr;
    int pc;
    int da;
    int aa;
    int ba;
    int fs;
    int mb;
    int imm;
    int rs;
    int rw;
    int mw;
    int asel;
    int lat;
    int nxt;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] instr, input int pc, input int da, input int aa,
                              input int ba, input int fs, input int mb, input int immv,
                              input int rs, input int rw, input int mw, input int asel,
                              input int lat, input int nxt);
    exp_t e;
    e.instr = instr; e.pc = pc; e.da = da; e.aa = aa; e.ba = ba; e.fs = fs; e.mb = mb;
    e.imm = immv; e.rs = rs; e.rw = rw; e.mw = mw; e.asel = asel; e.lat = lat; e.nxt = nxt;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          rw_cnt = 0;
  int          mw_cnt = 0;
  bit          chk_next = 1'b0;
  logic [15:0] next_pc = 16'h0000;
  exp_t        em;

  always @(negedge clk) begin
    if (reset) begin
      cyc = 0; rw_cnt = 0; mw_cnt = 0; chk_next = 1'b0;
    end else begin
      cyc++;
      if (chk_next) begin
        chk("next_pc", 32'(PC), 32'(next_pc));
        chk_next = 1'b0;
      end
      rw_cnt += int'(RW);
      mw_cnt += int'(memWrite);
      if (instrDone) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(instrDone), 32'd0);
        end else begin
          em = sb.pop_front();
          chk($sformatf("%04h PC", em.instr), 32'(PC), em.pc);
          if (em.da >= 0) chk($sformatf("%04h DA", em.instr), 32'(DA), em.da);
          if (em.aa >= 0) chk($sformatf("%04h AA", em.instr), 32'(AA), em.aa);
          if (em.ba >= 0) chk($sformatf("%04h BA", em.instr), 32'(BA), em.ba);
          if (em.fs >= 0) chk($sformatf("%04h FS", em.instr), 32'(FS), em.fs);
          if (em.mb >= 0) chk($sformatf("%04h MB", em.instr), 32'(MB), em.mb);
          if (em.imm >= 0) chk($sformatf("%04h imm", em.instr), 32'(imm), em.imm);
          if (em.rs >= 0) chk($sformatf("%04h rs", em.instr), 32'(resultSource), em.rs);
          chk($sformatf("%04h addrSel", em.instr), 32'(addrSel), em.asel);
          chk($sformatf("%04h RW_pulses", em.instr), rw_cnt, em.rw);
          chk($sformatf("%04h memWrite_pulses", em.instr), mw_cnt, em.mw);
          chk($sformatf("%04h latency", em.instr), cyc, em.lat);
          next_pc  = em.nxt[15:0];
          chk_next = 1'b1;
        end
        cyc = 0; rw_cnt = 0; mw_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at the start of a FETCH cycle; returns at the start of the next one.
  task automatic issue(input exp_t e, input logic z, input logic n);
    int k;
    MemIn = e.instr; zero = z; negative = n;
    sb.push_back(e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (instrDone !== 1'b1 && k < 8);
    chk($sformatf("%04h done_seen", e.instr), 32'(instrDone), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_PC", 32'(PC), 32'h0000);
    chk("rst_regs", 32'({DA, AA, BA, FS, MB}), 32'd0);
    chk("rst_imm_rs", 32'({imm, resultSource}), 32'd0);
    chk("rst_enables", 32'({RW, memWrite, instrDone, halted, addrSel}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //          instr     pc     da  aa  ba  fs  mb  imm      rs  rw mw as lat next
    issue(mk(16'h0312, 1,      3,  1,  2,  0,  0,  0,       0,  1, 0, 0, 3, 1),      0, 0);
    issue(mk(16'h94F0, 2,      4, -1, -1, -1, -1,  16'hFFF0, 3, 1, 0, 0, 3, 2),      0, 0);
    issue(mk(16'h8457, 3,      4,  5, -1,  0,  1,  7,       0,  1, 0, 0, 3, 3),      0, 0);
    issue(mk(16'hA230, 4,      2,  3, -1,  0,  1,  0,       1,  1, 0, 1, 4, 4),      0, 0);
    issue(mk(16'hB045, 5,     -1,  4,  5,  0,  1,  0,      -1,  0, 1, 1, 4, 5),      0, 0);
    issue(mk(16'hC1FC, 6,     -1,  1, -1,  0,  1,  0,      -1,  0, 0, 0, 3, 2),      1, 0);
    issue(mk(16'h1123, 3,      1,  2,  3,  1,  0,  0,       0,  1, 0, 0, 3, 3),      0, 0);
    issue(mk(16'h2456, 4,      4,  5,  6,  2,  0,  0,       0,  1, 0, 0, 3, 4),      0, 0);
    issue(mk(16'h7ABC, 5,     10, 11, 12,  7,  0,  0,       0,  1, 0, 0, 3, 5),      0, 0);
    issue(mk(16'hC1FC, 6,     -1,  1, -1,  0,  1,  0,      -1,  0, 0, 0, 3, 6),      0, 1);
    issue(mk(16'hD010, 7,     -1,  0, -1,  0,  1,  0,      -1,  0, 0, 0, 3, 16'h17), 0, 1);
    issue(mk(16'hD010, 16'h18,-1,  0, -1,  0,  1,  0,      -1,  0, 0, 0, 3, 16'h18), 1, 0);
    issue(mk(16'hE7EF, 16'h19, 7, -1, -1, -1, -1, -1,       2,  1, 0, 0, 3, 8),      0, 0);
    issue(mk(16'hE703, 9,      7, -1, -1, -1, -1, -1,       2,  1, 0, 0, 3, 16'hC),  0, 0);
    issue(mk(16'hC0FF, 16'hD, -1,  0, -1,  0,  1,  0,      -1,  0, 0, 0, 3, 16'hC),  1, 0);
    issue(mk(16'hE180, 16'hD,  1, -1, -1, -1, -1, -1,       2,  1, 0, 0, 3, 16'hFF8D), 0, 0);
    issue(mk(16'hD171, 16'hFF8E,-1, 1, -1,  0,  1,  0,      -1,  0, 0, 0, 3, 16'hFFFF), 0, 1);
    issue(mk(16'h0312, 0,      3,  1,  2,  0,  0,  0,       0,  1, 0, 0, 3, 0),      0, 0);

    // HALT at PC 0: stays halted with PC frozen at 1, no enables.
    MemIn = 16'hF000; zero = 1'b0; negative = 1'b0;
    repeat (3) @(negedge clk);
    MemIn = 16'h0312;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("halt_cycle%0d", i), 32'({halted, RW, memWrite, instrDone, PC}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0001}));
    end

    // Reset out of HALT, then abort a store in its MEM cycle.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; MemIn = 16'hB045;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(negedge clk);
    chk("st_mem_before_reset", 32'({addrSel, memWrite}), 32'b11);
    @(negedge clk);
    chk("abort_memWrite", 32'(memWrite), 32'd0);
    chk("abort_addrSel_done", 32'({addrSel, instrDone, RW}), 32'd0);
    chk("abort_PC", 32'(PC), 32'h0000);
    chk("abort_IR_cleared", 32'({AA, BA}), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    issue(mk(16'h0312, 1,      3,  1,  2,  0,  0,  0,       0,  1, 0, 0, 3, 1),      0, 0);
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
